// File: rtl/seq_alu_pkg.sv
// Shared opcodes, result constants and state/select enums for the sequential ALU.
package seq_alu_pkg;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_DIVU = 4'd9;
   localparam logic [3:0] OP_REMU = 4'd10;
   localparam logic [3:0] OP_NOR  = 4'd12;

   localparam int DEFAULT_RESULT = 42;

   typedef enum logic [2:0] {IDLE, ONE, MUL, DIV, FIN} alu_state_t;

   typedef enum logic [1:0] {MD_MUL, MD_DIVU, MD_REMU} md_sel_t;

endpackage

// File: rtl/seq_alu_if.sv
// Start/Busy/Done request bus of the sequential ALU.
// Start is taken only while Busy=0; Done pulses for one cycle with Out valid in that cycle.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [3:0]       Control;
   logic [WIDTH-1:0] Input1;
   logic [WIDTH-1:0] Input2;
   logic [WIDTH-1:0] Out;
   logic             Zero;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, Control, Input1, Input2,
      input  Out, Zero, Busy, Done
   );

   modport slave (
      input  Start, Control, Input1, Input2,
      output Out, Zero, Busy, Done
   );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle for WIDTH cycles.
// The divider path is built only when SEQ_ALU_DIV_EN is defined.
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             load_i,
   input  md_sel_t          sel_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             last_o
);

   // p: product accumulator / partial remainder, x: multiplicand / quotient, y: multiplier / divisor
   logic             run_q, run_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   md_sel_t          sel_q, sel_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   assign shifted = {p_q, x_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, y_q};
`endif

   assign last_o   = run_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign result_o = (sel_q == MD_DIVU) ? x_q : p_q;

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      sel_d = sel_q;
      p_d   = p_q;
      x_d   = x_q;
      y_d   = y_q;
      if (load_i) begin
         run_d = 1'b1;
         cnt_d = '0;
         sel_d = sel_i;
         p_d   = '0;
         x_d   = a_i;
         y_d   = b_i;
      end else if (run_q) begin
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
         run_d = !last_o;
`ifdef SEQ_ALU_DIV_EN
         if (sel_q != MD_MUL) begin
            // A zero divisor never goes negative: quotient fills with ones, remainder ends as A
            if (!diff[WIDTH]) begin
               p_d = diff[WIDTH-1:0];
               x_d = {x_q[WIDTH-2:0], 1'b1};
            end else begin
               p_d = shifted[WIDTH-1:0];
               x_d = {x_q[WIDTH-2:0], 1'b0};
            end
         end else
`endif
         begin
            if (y_q[0]) p_d = p_q + x_q;
            x_d = x_q << 1;
            y_d = y_q >> 1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         sel_q <= MD_MUL;
         p_q   <= '0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         sel_q <= sel_d;
         p_q   <= p_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: control FSM, single-cycle ops, registered result and Start/Busy/Done handshake.
// Define SEQ_ALU_DIV_EN to enable DIVU/REMU; otherwise opcodes 9 and 10 return the default result.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic       Clock,
   input  logic       Reset,
   seq_alu_if.slave   bus,
   output alu_state_t dbg_state_o
);

   alu_state_t       state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             done_q, done_d;

   logic             md_load;
   md_sel_t          md_sel;
   logic [WIDTH-1:0] md_result;
   logic             md_last;
   logic [WIDTH-1:0] one_result;

   assign md_sel = (bus.Control == OP_DIVU) ? MD_DIVU :
                   (bus.Control == OP_REMU) ? MD_REMU : MD_MUL;

   seq_alu_muldiv #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .Clock    (Clock),
      .Reset    (Reset),
      .load_i   (md_load),
      .sel_i    (md_sel),
      .a_i      (bus.Input1),
      .b_i      (bus.Input2),
      .result_o (md_result),
      .last_o   (md_last)
   );

   always_comb begin
      one_result = WIDTH'(DEFAULT_RESULT);
      case (op_q)
         OP_AND:  one_result = a_q & b_q;
         OP_OR:   one_result = a_q | b_q;
         OP_ADD:  one_result = a_q + b_q;
         OP_SUB:  one_result = a_q - b_q;
         OP_SLT:  one_result = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
         OP_NOR:  one_result = ~(a_q | b_q);
         default: one_result = WIDTH'(DEFAULT_RESULT);
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      out_d   = out_q;
      done_d  = 1'b0;
      md_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               op_d = bus.Control;
               a_d  = bus.Input1;
               b_d  = bus.Input2;
               if (bus.Control == OP_MUL) begin
                  state_d = MUL;
                  md_load = 1'b1;
               end
`ifdef SEQ_ALU_DIV_EN
               else if (bus.Control == OP_DIVU || bus.Control == OP_REMU) begin
                  state_d = DIV;
                  md_load = 1'b1;
               end
`endif
               else begin
                  state_d = ONE;
               end
            end
         end
         ONE: begin
            out_d   = one_result;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         MUL, DIV: begin
            if (md_last) state_d = FIN;
         end
         FIN: begin
            out_d   = md_result;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign bus.Out     = out_q;
   assign bus.Zero    = (out_q == '0);
   assign bus.Busy    = (state_q != IDLE);
   assign bus.Done    = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised successor to the single-cycle datapath ALU. Keeps the existing 4-bit `Control` encoding and adds iterative unsigned multiply, divide and remainder. Uses a Start/Busy/Done handshake and registered outputs. Sits in the EX stage; the control unit stalls the pipeline while `Busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `CNT_W`, default `$clog2(WIDTH)+1`: iteration counter width; derived, do not override.

- `Clock`, in, 1: single clock; all state updates on its rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Start`, in, 1: request a new operation; accepted only when `Busy`=0.
- `Control`, in, 4: opcode, sampled on the accepted `Start`.
- `Input1`, in, WIDTH: operand A, sampled on the accepted `Start`.
- `Input2`, in, WIDTH: operand B, sampled on the accepted `Start`.
- `Out`, out, WIDTH: registered result; held until the next `Done`.
- `Zero`, out, 1: high when `Out`==0. Combinational from registered `Out`.
- `Busy`, out, 1: high while an operation is in flight.
- `Done`, out, 1: one-cycle pulse; `Out` is valid in that same cycle.

## Operation
- Opcodes:
  - 0 AND
  - 1 OR
  - 2 ADD (mod 2^WIDTH)
  - 6 SUB (mod 2^WIDTH)
  - 7 SLT, unsigned: result 1 if A<B, else 0
  - 12 NOR
  - 8 MUL: low WIDTH bits of A*B, shift-add
  - 9 DIVU: A/B quotient, restoring division
  - 10 REMU: A%B remainder
  - any other value: result 42
- FSM states:
  - IDLE → ONE on `Start` with a single-cycle op (0, 1, 2, 6, 7, 12, default).
  - IDLE → MUL on `Start` with op 8.
  - IDLE → DIV on `Start` with op 9 or 10.
  - ONE → IDLE: write `Out`, pulse `Done`.
  - MUL and DIV each run exactly WIDTH iterations, one bit per cycle, then → FIN.
  - FIN → IDLE: write `Out`, pulse `Done`.
- Operands and opcode are latched at accept; input changes after accept have no effect.
- Divide by zero: quotient = all ones, remainder = A. Latency is the normal divide latency.
- `Start` while `Busy`=1 is ignored: not queued, no error.
- `Start` in the cycle `Done` is high is legal, because `Busy` is already 0.

## Timing
- Reset values: `Out`=0, `Zero`=1, `Busy`=0, `Done`=0, FSM=IDLE, counter=0.
- `Start` accepted at edge t.
- Single-cycle op:
  - `Busy`=1 in cycle t+1.
  - `Done`=1 and `Out` valid at t+2.
  - Start-to-Done latency is 2 cycles.
- MUL/DIV:
  - `Busy`=1 from t+1 through t+WIDTH+1.
  - `Done`=1 at t+WIDTH+2.
  - Latency is WIDTH+2 cycles (34 at WIDTH=32).
- `Done` is never high in two consecutive cycles unless a back-to-back `Start` was issued in a `Done` cycle.
- `Reset` asserted mid-operation:
  - Aborts at the next edge and returns to the reset values.
  - No `Done` is produced for the aborted operation.
  - `Start` in the same cycle as `Reset` is dropped.

## Configuration
- `SEQ_ALU_DIV_EN` defined: opcodes 9 and 10 perform DIVU and REMU as above.
- Not defined:
  - The divider datapath and DIV state are absent.
  - Opcodes 9 and 10 behave as default: result 42 via ONE, 2-cycle latency.
  - MUL is unaffected.

## Structure
- Package `seq_alu_pkg` holds:
  - opcode localparams: `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`, `OP_MUL`, `OP_DIVU`, `OP_REMU`, `OP_NOR`;
  - `DEFAULT_RESULT`=42;
  - the FSM state enum `alu_state_t` (IDLE, ONE, MUL, DIV, FIN).
- Sub-module `seq_alu_muldiv` holds the iterative shift-add/restoring-divide datapath and its counter. Its ports are `Clock`, `Reset`, load, op select, operands, result and last-iteration flag.
- Top level keeps the FSM, the single-cycle combinational ops, the output register and the handshake.

## Test plan
- Reset then idle: `Out`=0, `Zero`=1, `Busy`=0, `Done`=0. `Start` with op 2, A=5, B=7 → `Done` 2 cycles later, `Out`=12, `Zero`=0.
- Op 6, A=3, B=3 → `Out`=0, `Zero`=1. Op 7, A=1, B=0xFFFFFFFF → `Out`=1. Op 5 → `Out`=42.
- Op 8, A=0x10001, B=0x10001 → `Done` at cycle 34, `Out`=0x00020001 (wrapped). Extra `Start` pulses during `Busy` are ignored.
- Op 9, A=100, B=7 → `Out`=14. Op 10 → `Out`=2. Op 9, B=0 → `Out`=0xFFFFFFFF. Op 10, B=0 → `Out`=100. Without `SEQ_ALU_DIV_EN`: op 9 → `Out`=42 after 2 cycles.
- Op 8 started, `Reset` pulsed at cycle 10 → no `Done`, outputs at reset values. A new op 2 issued afterwards completes normally.
- Back-to-back: a new `Start` in the `Done` cycle is accepted. `Out` holds the first result until the second `Done`.
